// File: rtl/vga_pkg.sv
// Screen geometry and framebuffer addressing shared by every framebuffer client.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    // y*160 + x built from shifts so no multiplier is needed; fits in 15 bits (max 19199).
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] px, input logic [7:0] py);
        logic [ADDR_W-1:0] xw;
        logic [ADDR_W-1:0] yw;
        xw = ADDR_W'(px);
        yw = ADDR_W'(py);
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO holding {address, colour} entries between pixel producers and the framebuffer.
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when the same cycle pops.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_plot_receiver.sv
// Accepts (x, y, colour) plots, drops off-screen ones, and streams linear framebuffer writes.
module pixel_plot_receiver
    import vga_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                plot,
    input  logic [7:0]          x,
    input  logic [7:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                plot_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    input  logic                mem_ready,
    output logic                busy,
    output logic [7:0]          drop_count
);

    localparam int         EW    = ADDR_W + COLOUR_W;
    localparam int         CW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] X_LIM = 8'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    logic          in_range;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [EW-1:0] din;
    logic [EW-1:0] dout;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high
    // (plot/plot_ready upstream, mem_we/mem_ready downstream); valid-side data is held until then.
    assign in_range   = (x < X_LIM) && (y < Y_LIM);
    assign plot_ready = !full;
    assign accept     = plot && plot_ready;
    assign push       = accept && in_range;
    assign mem_we     = !empty;
    assign busy       = mem_we;
    assign pop        = mem_we && mem_ready;
    assign din        = {xy_to_addr(x, y), colour};
    assign mem_addr   = mem_we ? dout[EW-1:COLOUR_W] : '0;
    assign mem_data   = mem_we ? dout[COLOUR_W-1:0]  : '0;

    plot_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .dout   (dout),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Directed bench for pixel_plot_receiver with a cycle-level expected-queue scoreboard.
module tb_pixel_plot_receiver;

    logic        clk;
    logic        resetn;
    logic        plot;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot_ready;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_ready;
    logic        busy;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [17:0] exp_q[$];
    int          model_drop = 0;

    pixel_plot_receiver dut (
        .clk        (clk),
        .resetn     (resetn),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot_ready (plot_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .drop_count (drop_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_plot(input int px, input int py, input int c);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 8'(py);
        colour = 3'(c);
    endtask

    task automatic idle();
        plot = 1'b0;
        x    = '0;
        y    = '0;
    endtask

    // Scoreboard: checks outputs against the model, then applies the coming edge's events.
    always @(negedge clk) begin
        if (mon_en) begin
            bit full_b;
            check_val("sb_ready", 32'(plot_ready), 32'(exp_q.size() != 4));
            check_val("sb_we",    32'(mem_we),     32'(exp_q.size() != 0));
            check_val("sb_busy",  32'(busy),       32'(exp_q.size() != 0));
            check_val("sb_drop",  32'(drop_count), 32'(model_drop));
            if (exp_q.size() != 0) begin
                check_val("sb_addr", 32'(mem_addr), 32'(exp_q[0][17:3]));
                check_val("sb_data", 32'(mem_data), 32'(exp_q[0][2:0]));
            end else begin
                check_val("sb_addr_idle", 32'(mem_addr), 32'd0);
            end
            if (!resetn) begin
                exp_q.delete();
                model_drop = 0;
            end else begin
                full_b = (exp_q.size() == 4);
                if (exp_q.size() != 0 && mem_ready) void'(exp_q.pop_front());
                if (plot && !full_b) begin
                    if (x < 160 && y < 120)
                        exp_q.push_back({15'(int'(y) * 160 + int'(x)), colour});
                    else if (model_drop != 255)
                        model_drop++;
                end
            end
        end
    end

    int xs[6]    = '{1, 2, 100, 159, 0, 50};
    int ys[6]    = '{1, 3, 50, 0, 119, 100};
    int addrs[6] = '{161, 482, 8100, 159, 19040, 16050};

    initial begin
        resetn = 1'b0; mem_ready = 1'b0; colour = '0;
        idle();
        step(); step();
        resetn = 1'b1;
        mon_en = 1'b1;
        check_val("rst_we",    32'(mem_we),     0);
        check_val("rst_busy",  32'(busy),       0);
        check_val("rst_ready", 32'(plot_ready), 1);
        check_val("rst_addr",  32'(mem_addr),   0);
        check_val("rst_data",  32'(mem_data),   0);
        check_val("rst_drop",  32'(drop_count), 0);

        // single pixel latency
        mem_ready = 1'b1;
        drive_plot(0, 0, 7);
        step(); idle();
        check_val("t1_we",   32'(mem_we),   1);
        check_val("t1_addr", 32'(mem_addr), 0);
        check_val("t1_data", 32'(mem_data), 7);
        step();
        check_val("t1_we_off", 32'(mem_we), 0);

        // bottom-right corners
        drive_plot(159, 119, 5);
        step(); drive_plot(158, 119, 2);
        check_val("t2_addr0", 32'(mem_addr), 19199);
        check_val("t2_data0", 32'(mem_data), 5);
        step(); idle();
        check_val("t2_addr1", 32'(mem_addr), 19198);
        check_val("t2_data1", 32'(mem_data), 2);
        step();
        check_val("t2_we_off", 32'(mem_we),     0);
        check_val("t2_drop",   32'(drop_count), 0);

        // off-screen plots are dropped
        drive_plot(160, 0, 1);
        step(); drive_plot(0, 120, 1);
        check_val("t3_we0",    32'(mem_we),     0);
        check_val("t3_ready0", 32'(plot_ready), 1);
        step(); idle();
        check_val("t3_we1",    32'(mem_we),     0);
        check_val("t3_drop",   32'(drop_count), 2);
        check_val("t3_ready1", 32'(plot_ready), 1);

        // back-pressure: fill, hold head, drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_plot(10 + i, i, i + 1);
            step();
        end
        check_val("t4_ready_full", 32'(plot_ready), 0);
        check_val("t4_head0",      32'(mem_addr),   10);
        step();
        check_val("t4_ready_hold", 32'(plot_ready), 0);
        check_val("t4_head_hold",  32'(mem_addr),   10);
        check_val("t4_data_hold",  32'(mem_data),   1);
        mem_ready = 1'b1;
        step();
        check_val("t4_ready_reopen", 32'(plot_ready), 1);
        check_val("t4_head1",        32'(mem_addr),   171);
        step(); idle();
        check_val("t4_head2", 32'(mem_addr), 332);
        step();
        check_val("t4_head3", 32'(mem_addr), 493);
        step();
        check_val("t4_head4", 32'(mem_addr), 654);
        check_val("t4_data4", 32'(mem_data), 5);
        step();
        check_val("t4_we_off", 32'(mem_we), 0);

        // streaming at one pixel per cycle
        for (int i = 0; i < 6; i++) begin
            drive_plot(xs[i], ys[i], i);
            step();
            check_val("t5_we",    32'(mem_we),     1);
            check_val("t5_addr",  32'(mem_addr),   32'(addrs[i]));
            check_val("t5_ready", 32'(plot_ready), 1);
        end
        idle();
        step();
        check_val("t5_we_off", 32'(mem_we), 0);

        // reset with entries queued
        mem_ready = 1'b0;
        drive_plot(200, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_plot(i, i, 3);
            step();
        end
        idle();
        check_val("t6_pre_busy", 32'(busy),       1);
        check_val("t6_pre_drop", 32'(drop_count), 3);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_val("t6_we",    32'(mem_we),     0);
        check_val("t6_busy",  32'(busy),       0);
        check_val("t6_ready", 32'(plot_ready), 1);
        check_val("t6_drop",  32'(drop_count), 0);
        mem_ready = 1'b1;
        step();
        check_val("t6_we_after", 32'(mem_we), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
